// File: rtl/counter_scheduler_pkg.sv
// Shared types and default sizes for the counter scheduler.
// Optional feature macro: CNT_SCHED_PAUSE_EN (adds a pause input to the top).
package cnt_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Default sizing used by the top and the arbiter
    localparam int CNT_W_DEF   = 4;
    localparam int NUM_REQ_DEF = 4;

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after 'last',
// wrapping around, and returns both a one-hot grant and its index.
module rr_arbiter
    import cnt_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    // Scan offsets 1..NUM_REQ from last; the first set request wins
    always_comb begin
        logic found;
        int   pos;
        gnt   = '0;
        idx   = last;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = int'(last) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one CNT_W-bit up-counter among NUM_REQ requesters. Each granted
// requester receives a window in which the counter runs 0..req_len, then a
// one-cycle done pulse. Requesters are served in round-robin order.
// Optional feature macro: CNT_SCHED_PAUSE_EN (pause input: holds the counter
// in RUN and blocks new grants in IDLE; no effect in GRANT or DONE).
module counter_scheduler
    import cnt_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef CNT_SCHED_PAUSE_EN
    input  logic                     pause,
`endif
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [IDX_W-1:0]         owner,
    output logic [CNT_W-1:0]         count
);

    sched_state_t        r_state;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_target;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_last;
    logic [NUM_REQ-1:0]  r_gnt_oh;
    logic [NUM_REQ-1:0]  r_ready;
    logic [NUM_REQ-1:0]  r_done;
    logic                r_busy;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]    w_idx;
    logic                w_pause;
    logic                w_any_req;
    logic [CNT_W-1:0]    w_len_arr [NUM_REQ];

`ifdef CNT_SCHED_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_any_req = |req_valid;

    // Unpack the per-requester terminal counts
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
        assign w_len_arr[gi] = req_len[gi*CNT_W +: CNT_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req  (req_valid),
        .last (r_last),
        .gnt  (w_gnt),
        .idx  (w_idx)
    );

    // Scheduler FSM: grant, count the window, pulse done; all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_target <= '0;
            r_owner  <= '0;
            r_last   <= IDX_W'(NUM_REQ - 1);
            r_gnt_oh <= '0;
            r_ready  <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_ready <= '0;
            r_done  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any_req && !w_pause) begin
                        // Target is latched here; later changes to req_len are ignored
                        r_owner  <= w_idx;
                        r_target <= w_len_arr[w_idx];
                        r_gnt_oh <= w_gnt;
                        r_ready  <= w_gnt;
                        r_busy   <= 1'b1;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    r_count <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    if (!w_pause) begin
                        if (r_count == r_target) begin
                            // Counter stops at the target, so it never wraps
                            r_done  <= r_gnt_oh;
                            r_state <= DONE;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_last  <= r_owner;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign done      = r_done;
    assign busy      = r_busy;
    assign owner     = r_owner;
    assign count     = r_count;

endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler. Expected behaviour comes from a
// window-level timeline model: winner by round-robin rule, ready one cycle
// after the idle decision, count 0..len, done at len+3, idle at len+4.
// Optional feature macro: CNT_SCHED_PAUSE_EN (adds pause scenarios).
module tb_counter_scheduler;

    localparam int NR = 4;
    localparam int CW = 4;
    localparam int IW = $clog2(NR);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*CW-1:0]  req_len = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     done;
    logic              busy;
    logic [IW-1:0]     owner;
    logic [CW-1:0]     count;
`ifdef CNT_SCHED_PAUSE_EN
    logic              pause = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int m_last = NR - 1;

    counter_scheduler #(.NUM_REQ(NR), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CNT_SCHED_PAUSE_EN
        .pause     (pause),
`endif
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .done      (done),
        .busy      (busy),
        .owner     (owner),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first valid index after last, with wrap
    function automatic int rr_pick(input logic [NR-1:0] m, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (m[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic set_len(input int i, input int v);
        req_len[i*CW +: CW] = CW'(v);
    endtask

    function automatic int get_len(input int i);
        return int'(req_len[i*CW +: CW]);
    endfunction

    // Called at the negedge of the idle cycle in which the request is visible
    task automatic window(input int own, input bit drop);
        int len;
        len = get_len(own);
        @(negedge clk);
        chk("grant_ready", req_ready, 32'(1) << own);
        chk("grant_busy", busy, 1);
        chk("grant_owner", owner, own);
        chk("grant_done", done, 0);
        if (drop) req_valid[own] = 1'b0;
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            chk("run_count", count, k);
            chk("run_ready", req_ready, 0);
            chk("run_done", done, 0);
            chk("run_busy", busy, 1);
            for (int j = 0; j < NR; j++) begin
                if (j != own && !req_valid[j]) set_len(j, $urandom_range(0, 15));
            end
        end
        @(negedge clk);
        chk("done_pulse", done, 32'(1) << own);
        chk("done_count", count, len);
        chk("done_busy", busy, 1);
        chk("done_ready", req_ready, 0);
        m_last = own;
    endtask

    task automatic serve_all();
        int w;
        while (req_valid != '0) begin
            w = rr_pick(req_valid, m_last);
            window(w, 1'b1);
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end
    endtask

    initial begin
        int seq [5];

        // Reset held with random inputs
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = NR'($urandom);
            req_len   = (NR*CW)'($urandom);
            #1;
            chk("rst_count", count, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_done", done, 0);
            chk("rst_owner", owner, 0);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_count", count, 0);
        end

        // Single request, len 3
        set_len(0, 3);
        req_valid = 4'b0001;
        window(0, 1'b1);
        @(negedge clk);
        chk("single_idle_busy", busy, 0);
        chk("single_idle_count", count, 3);

        // Contention: all valid, len 0, from a fresh reset
        rst = 1'b0;
        m_last = NR - 1;
        @(negedge clk);
        rst = 1'b1;
        req_len = '0;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            window(rr_pick(req_valid, m_last), 1'b0);
            seq[i] = int'(owner);
            @(negedge clk);
            chk("cont_idle_busy", busy, 0);
        end
        for (int i = 0; i < 5; i++) chk("cont_owner_seq", seq[i], i % NR);
        req_valid = '0;
        @(negedge clk);

        // Boundaries: len 0 and len 15
        set_len(2, 0);
        req_valid = 4'b0100;
        serve_all();
        set_len(1, 15);
        req_valid = 4'b0010;
        serve_all();

        // Reset in the middle of a len-9 window at count 5
        set_len(3, 9);
        req_valid = 4'b1000;
        @(negedge clk);
        chk("mid_ready", req_ready, 4'b1000);
        req_valid = '0;
        repeat (6) @(negedge clk);
        chk("mid_count5", count, 5);
        rst = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_owner", owner, 0);
        m_last = NR - 1;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("mid_no_done", done, 0);
            chk("mid_idle_busy", busy, 0);
        end
        for (int i = 0; i < NR; i++) set_len(i, $urandom_range(0, 15));
        req_valid = 4'b1111;
        serve_all();

        // Randomized request sets
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NR; i++) set_len(i, $urandom_range(0, 15));
            req_valid = NR'($urandom_range(1, 15));
            serve_all();
        end

`ifdef CNT_SCHED_PAUSE_EN
        // Pause for 3 cycles at count 2 of len 4
        set_len(1, 4);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("p_ready", req_ready, 4'b0010);
        req_valid = '0;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            chk("p_count", count, k);
        end
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("p_hold_count", count, 2);
            chk("p_hold_done", done, 0);
            chk("p_hold_busy", busy, 1);
        end
        pause = 1'b0;
        @(negedge clk);
        chk("p_count3", count, 3);
        @(negedge clk);
        chk("p_count4", count, 4);
        chk("p_not_done_yet", done, 0);
        @(negedge clk);
        chk("p_done", done, 4'b0010);
        m_last = 1;
        @(negedge clk);
        chk("p_idle_busy", busy, 0);

        // Pause in IDLE blocks grants
        set_len(0, 2);
        pause = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("p_idle_blocked_busy", busy, 0);
            chk("p_idle_blocked_ready", req_ready, 0);
        end
        pause = 1'b0;
        serve_all();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
